// File: rtl/dds_pkg.sv
// Shared types and defaults for the DDS front-panel entry path.
// Digit, state and range definitions used by the entry and display logic.
package dds_pkg;

    localparam int NDIG_DEF     = 6;
    localparam int BIN_W_DEF    = 20;
    localparam int MAX_FREQ_DEC = 999999;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

endpackage

// File: rtl/bcd_digit_step.sv
// Single BCD digit step: +1 or -1 modulo 10.
// No carry or borrow leaves the digit.
module bcd_digit_step
    import dds_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_up,
    output logic [3:0] o_digit
);

    // Wrap 9->0 going up and 0->9 going down
    always_comb begin
        o_digit = i_digit;
        if (i_up) begin
            o_digit = (i_digit == 4'd9) ? 4'd0 : i_digit + 4'd1;
        end else begin
            o_digit = (i_digit == 4'd0) ? 4'd9 : i_digit - 4'd1;
        end
    end

endmodule

// File: rtl/digit_entry.sv
// Front-panel decimal setpoint editor with BCD-to-binary publish.
// Keys edit digits in IDLE; ok converts MSD-first and publishes clamped.
module digit_entry
    import dds_pkg::*;
#(
    parameter int                NDIG      = NDIG_DEF,
    parameter int                BIN_W     = BIN_W_DEF,
    parameter int                MAX_VAL   = MAX_FREQ_DEC,
    parameter logic [4*NDIG-1:0] RESET_BCD = 24'h001000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_left,
    input  logic              key_right,
    input  logic              key_inc,
    input  logic              key_dec,
    input  logic              key_ok,
    output logic [4*NDIG-1:0] edit_bcd,
    output logic [2:0]        cursor,
    output logic              busy,
    output logic [BIN_W-1:0]  bin,
    output logic              bin_valid,
    output logic              clamped
);

    localparam int ACC_W = BIN_W + 4;

    function automatic logic [ACC_W-1:0] bcd2bin(
        input logic [4*NDIG-1:0] b
    );
        logic [ACC_W-1:0] a;
        a = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            a = (a << 3) + (a << 1) + ACC_W'(b[4*i +: 4]);
        end
        return a;
    endfunction

    localparam logic [ACC_W-1:0] MAX_ACC   = ACC_W'(MAX_VAL);
    localparam logic [ACC_W-1:0] RESET_ACC = bcd2bin(RESET_BCD);
    localparam logic [BIN_W-1:0] RESET_BIN =
        (RESET_ACC > MAX_ACC) ? MAX_ACC[BIN_W-1:0]
                              : RESET_ACC[BIN_W-1:0];
    localparam logic [2:0]       LAST_CUR  = 3'(NDIG - 1);

    state_t            r_state;
    logic [4*NDIG-1:0] r_bcd;
    logic [4*NDIG-1:0] r_shadow;
    logic [2:0]        r_cursor;
    logic [2:0]        r_idx;
    logic [ACC_W-1:0]  r_acc;
    logic [BIN_W-1:0]  r_bin;
    logic              r_bin_valid;
    logic              r_clamped;

    logic [4:0]        w_cur_lsb;
    logic [4:0]        w_idx_lsb;
    bcd_t              w_cur_dig;
    bcd_t              w_step_dig;
    bcd_t              w_shadow_dig;
    logic [ACC_W-1:0]  w_acc_next;
    logic              w_over;

    assign w_cur_lsb    = {r_cursor, 2'b00};
    assign w_idx_lsb    = {r_idx, 2'b00};
    assign w_cur_dig    = r_bcd[w_cur_lsb +: 4];
    assign w_shadow_dig = r_shadow[w_idx_lsb +: 4];
    assign w_acc_next   = (r_acc << 3) + (r_acc << 1)
                        + ACC_W'(w_shadow_dig);
    assign w_over       = (r_acc > MAX_ACC);

    bcd_digit_step u_step (
        .i_digit (w_cur_dig),
        .i_up    (key_inc),
        .o_digit (w_step_dig)
    );

    // Edit FSM: key handling in IDLE, digit-serial conversion, publish
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bcd       <= RESET_BCD;
            r_shadow    <= '0;
            r_cursor    <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_bin       <= RESET_BIN;
            r_bin_valid <= 1'b0;
            r_clamped   <= 1'b0;
        end else begin
            r_bin_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (key_ok) begin
                        r_shadow <= r_bcd;
                        r_acc    <= '0;
                        r_idx    <= LAST_CUR;
                        r_state  <= CONV;
                    end else if (key_inc || key_dec) begin
                        r_bcd[w_cur_lsb +: 4] <= w_step_dig;
                    end else if (key_left) begin
                        r_cursor <= (r_cursor == LAST_CUR)
                                  ? 3'd0 : r_cursor + 3'd1;
                    end else if (key_right) begin
                        r_cursor <= (r_cursor == 3'd0)
                                  ? LAST_CUR : r_cursor - 3'd1;
                    end
                end
                CONV: begin
                    r_acc <= w_acc_next;
                    if (r_idx == 3'd0) begin
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx - 3'd1;
                    end
                end
                DONE: begin
                    r_bin       <= w_over ? MAX_ACC[BIN_W-1:0]
                                          : r_acc[BIN_W-1:0];
                    r_clamped   <= w_over;
                    r_bin_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign edit_bcd  = r_bcd;
    assign cursor    = r_cursor;
    assign busy      = (r_state != IDLE);
    assign bin       = r_bin;
    assign bin_valid = r_bin_valid;
    assign clamped   = r_clamped;

endmodule

// File: tb/tb_digit_entry.sv
// Self-checking bench for digit_entry (default and 500000-clamp builds).
// Table-driven edits plus scoreboarded conversion results.
module tb_digit_entry;

    localparam int K_INC   = 0;
    localparam int K_DEC   = 1;
    localparam int K_LEFT  = 2;
    localparam int K_RIGHT = 3;

    typedef struct {
        int          key;
        logic [23:0] bcd;
        logic [2:0]  cur;
    } vec_t;

    typedef struct {
        logic [19:0] bin;
        logic        clamped;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_left  = 1'b0;
    logic key_right = 1'b0;
    logic key_inc   = 1'b0;
    logic key_dec   = 1'b0;
    logic key_ok    = 1'b0;

    logic [23:0] bcd_a, bcd_b;
    logic [2:0]  cur_a, cur_b;
    logic        busy_a, busy_b;
    logic [19:0] bin_a, bin_b;
    logic        bv_a, bv_b;
    logic        clp_a, clp_b;

    int checks = 0;
    int errors = 0;
    int n_va = 0;
    int n_vb = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    logic [23:0] m_bcd;
    int          m_cur;
    vec_t        tbl[19];

    always #5 clk = ~clk;

    digit_entry u_dut (
        .clk       (clk),
        .rst       (rst),
        .key_left  (key_left),
        .key_right (key_right),
        .key_inc   (key_inc),
        .key_dec   (key_dec),
        .key_ok    (key_ok),
        .edit_bcd  (bcd_a),
        .cursor    (cur_a),
        .busy      (busy_a),
        .bin       (bin_a),
        .bin_valid (bv_a),
        .clamped   (clp_a)
    );

    digit_entry #(.MAX_VAL(500000)) u_lim (
        .clk       (clk),
        .rst       (rst),
        .key_left  (key_left),
        .key_right (key_right),
        .key_inc   (key_inc),
        .key_dec   (key_dec),
        .key_ok    (key_ok),
        .edit_bcd  (bcd_b),
        .cursor    (cur_b),
        .busy      (busy_b),
        .bin       (bin_b),
        .bin_valid (bv_b),
        .clamped   (clp_b)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int bcd_val(input logic [23:0] b);
        int v = 0;
        int p = 1;
        for (int i = 0; i < 6; i++) begin
            v += int'(b[4*i +: 4]) * p;
            p *= 10;
        end
        return v;
    endfunction

    task automatic push_exp(input int v);
        exp_t e;
        e.bin = 20'(v);
        e.clamped = 1'b0;
        q_a.push_back(e);
        e.bin = (v > 500000) ? 20'd500000 : 20'(v);
        e.clamped = (v > 500000);
        q_b.push_back(e);
    endtask

    task automatic model_reset();
        m_bcd = 24'h001000;
        m_cur = 0;
    endtask

    task automatic press(input int k);
        int d;
        case (k)
            K_INC:   key_inc = 1'b1;
            K_DEC:   key_dec = 1'b1;
            K_LEFT:  key_left = 1'b1;
            default: key_right = 1'b1;
        endcase
        @(posedge clk); #1;
        key_inc = 1'b0;
        key_dec = 1'b0;
        key_left = 1'b0;
        key_right = 1'b0;
        d = int'(m_bcd[4*m_cur +: 4]);
        case (k)
            K_INC:   m_bcd[4*m_cur +: 4] = 4'((d + 1) % 10);
            K_DEC:   m_bcd[4*m_cur +: 4] = 4'((d + 9) % 10);
            K_LEFT:  m_cur = (m_cur + 1) % 6;
            default: m_cur = (m_cur + 5) % 6;
        endcase
        chk("model_bcd", bcd_a, m_bcd);
        chk("model_cur", cur_a, m_cur);
    endtask

    task automatic do_ok();
        int v;
        int n;
        v = bcd_val(m_bcd);
        push_exp(v);
        key_ok = 1'b1;
        @(posedge clk); #1;
        key_ok = 1'b0;
        n = 0;
        while (busy_a && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        chk("busy_cycles", n, 7);
        chk("valid_at_edge7", bv_a, 1);
        chk("bin_at_edge7", bin_a, v);
        @(posedge clk); #1;
        chk("valid_single", bv_a, 0);
    endtask

    task automatic chk_reset_state();
        chk("rst_bcd_a", bcd_a, 24'h001000);
        chk("rst_cur_a", cur_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_bin_a", bin_a, 1000);
        chk("rst_valid_a", bv_a, 0);
        chk("rst_clamp_a", clp_a, 0);
        chk("rst_bin_b", bin_b, 1000);
        chk("rst_clamp_b", clp_b, 0);
        chk("rst_busy_b", busy_b, 0);
    endtask

    // Scoreboard: every publish must match the oldest pending result
    always @(negedge clk) begin
        if (!rst) begin
            if (bv_a) begin
                n_va++;
                if (q_a.size() == 0) begin
                    chk("unexpected_valid_a", bin_a, 32'hFFFFFFFF);
                end else begin
                    ea = q_a.pop_front();
                    chk("sb_bin_a", bin_a, ea.bin);
                    chk("sb_clamp_a", clp_a, ea.clamped);
                end
            end
            if (bv_b) begin
                n_vb++;
                if (q_b.size() == 0) begin
                    chk("unexpected_valid_b", bin_b, 32'hFFFFFFFF);
                end else begin
                    eb = q_b.pop_front();
                    chk("sb_bin_b", bin_b, eb.bin);
                    chk("sb_clamp_b", clp_b, eb.clamped);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int guard;

        tbl[0] = '{K_INC,   24'h001001, 3'd0};
        tbl[1] = '{K_INC,   24'h001002, 3'd0};
        tbl[2] = '{K_INC,   24'h001003, 3'd0};
        tbl[3] = '{K_LEFT,  24'h001003, 3'd1};
        tbl[4] = '{K_DEC,   24'h001093, 3'd1};
        tbl[5] = '{K_DEC,   24'h001083, 3'd1};
        tbl[6] = '{K_RIGHT, 24'h001083, 3'd0};
        tbl[7] = '{K_RIGHT, 24'h001083, 3'd5};
        for (int i = 1; i <= 10; i++) begin
            tbl[7+i] = '{K_INC, {4'(i % 10), 20'h01083}, 3'd5};
        end
        tbl[18] = '{K_LEFT, 24'h001083, 3'd0};

        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk_reset_state();
        chk("no_valid_idle", n_va, 0);

        for (int i = 0; i < 6; i++) begin
            press(tbl[i].key);
            chk("tbl_bcd", bcd_a, tbl[i].bcd);
            chk("tbl_cur", cur_a, tbl[i].cur);
            chk("tbl_bcd_b", bcd_b, tbl[i].bcd);
        end
        do_ok();
        chk("clamp_1083", clp_a, 0);
        chk("bcd_kept", bcd_a, 24'h001083);

        for (int i = 6; i < 19; i++) begin
            press(tbl[i].key);
            chk("tbl_bcd", bcd_a, tbl[i].bcd);
            chk("tbl_cur", cur_a, tbl[i].cur);
        end

        for (int p = 0; p < 6; p++) begin
            guard = 0;
            while (m_bcd[4*m_cur +: 4] != 4'd9 && guard < 12) begin
                press(K_INC);
                guard++;
            end
            press(K_LEFT);
        end
        chk("all_nines", bcd_a, 24'h999999);
        do_ok();
        chk("bin_999999", bin_a, 20'hF423F);
        chk("clamp_def", clp_a, 0);
        chk("bin_lim", bin_b, 500000);
        chk("clamp_lim", clp_b, 1);

        n0 = n_va;
        push_exp(999999);
        key_ok = 1'b1;
        @(posedge clk); #1;
        key_ok = 1'b0;
        @(posedge clk); #1;
        key_inc = 1'b1;
        @(posedge clk); #1;
        key_inc = 1'b0;
        key_ok = 1'b1;
        @(posedge clk); #1;
        key_ok = 1'b0;
        chk("busy_mid", busy_a, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("busy_keys_bcd", bcd_a, 24'h999999);
        chk("busy_one_valid", n_va - n0, 1);
        chk("busy_done", busy_a, 0);

        n0 = n_va;
        push_exp(999999);
        key_ok = 1'b1;
        key_inc = 1'b1;
        @(posedge clk); #1;
        key_ok = 1'b0;
        key_inc = 1'b0;
        chk("ok_prio_busy", busy_a, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("ok_prio_bcd", bcd_a, 24'h999999);
        chk("ok_prio_valid", n_va - n0, 1);

        key_ok = 1'b1;
        @(posedge clk); #1;
        key_ok = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk_reset_state();
        n0 = n_va;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_valid", n_va - n0, 0);
        do_ok();
        chk("after_abort_bin", bin_a, 1000);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty_a", q_a.size(), 0);
        chk("sb_empty_b", q_b.size(), 0);
        chk("valid_count_b", n_vb, n_va);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
